// File: rtl/fetch_decode_pkg.sv
// fetch_decode_pkg: shared types and constants for the fetch/decode boundary.
//   state_t        : skid-buffer occupancy (EMPTY / ONE / FULL)
//   instr_fields_t : decoded instruction fields, immediate already sign-extended
//   *_MSB/*_LSB    : bit positions of each field in the 32-bit big-endian word
package fetch_decode_pkg;

  localparam int XLEN      = 32;
  localparam int OPCODE_W  = 6;
  localparam int REG_W     = 5;
  localparam int IMM_SRC_W = 16;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int RD_MSB     = 25;
  localparam int RD_LSB     = 21;
  localparam int RS1_MSB    = 20;
  localparam int RS1_LSB    = 16;
  localparam int RS2_MSB    = 15;
  localparam int RS2_LSB    = 11;
  localparam int IMM_MSB    = 15;
  localparam int IMM_LSB    = 0;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [OPCODE_W-1:0] opcode;
    logic [REG_W-1:0]    rd;
    logic [REG_W-1:0]    rs1;
    logic [REG_W-1:0]    rs2;
    logic [XLEN-1:0]     imm;
  } instr_fields_t;

endpackage

// File: rtl/instr_field_split.sv
// instr_field_split: purely combinational slicer of an instruction word into
// instr_fields_t. The 16-bit immediate is sign-extended to DATA_W.
//   instr  : DATA_W instruction word (byte 0 at [31:24])
//   fields : opcode / rd / rs1 / rs2 / imm
// Shared with the decoder, so it carries no state.
module instr_field_split
  import fetch_decode_pkg::*;
#(
  parameter int DATA_W = XLEN,
  parameter int IMM_W  = IMM_SRC_W
) (
  input  logic [DATA_W-1:0] instr,
  output instr_fields_t     fields
);

  always_comb begin
    fields        = '0;
    fields.opcode = instr[OPCODE_MSB:OPCODE_LSB];
    fields.rd     = instr[RD_MSB:RD_LSB];
    fields.rs1    = instr[RS1_MSB:RS1_LSB];
    // rs2 overlaps the top of the immediate; the opcode decides which is live.
    fields.rs2    = instr[RS2_MSB:RS2_LSB];
    fields.imm    = {{(DATA_W-IMM_W){instr[IMM_W-1]}}, instr[IMM_W-1:0]};
  end

endmodule

// File: rtl/fetch_decode_reg.sv
// fetch_decode_reg: 2-entry skid buffer between fetch and decode.
//   clk, rst (async, active-low), flush (sync, highest priority)
//   in_valid/in_ready/in_pc/in_instr : fetch side handshake
//   out_valid/out_ready/out_pc/out_instr + decoded fields : decode side
// The main register always drives the outputs; the skid register only holds
// the word accepted while downstream stalls. in_ready comes from the state
// register alone, so there is no out_ready -> in_ready combinational path.
// Optional: define FETCH_DECODE_STALL_CNT_EN to add the 16-bit saturating
// stall_cnt output (cycles with out_valid=1 and out_ready=0; cleared only by rst).
module fetch_decode_reg
  import fetch_decode_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int PC_W   = 8,
  parameter int IMM_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  input  logic [PC_W-1:0]     in_pc,
  input  logic [DATA_W-1:0]   in_instr,
  output logic                in_ready,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [PC_W-1:0]     out_pc,
  output logic [DATA_W-1:0]   out_instr,
  output logic [OPCODE_W-1:0] out_opcode,
  output logic [REG_W-1:0]    out_rd,
  output logic [REG_W-1:0]    out_rs1,
  output logic [REG_W-1:0]    out_rs2,
  output logic [DATA_W-1:0]   out_imm
`ifdef FETCH_DECODE_STALL_CNT_EN
  ,
  output logic [15:0]         stall_cnt
`endif
);

  state_t              state, state_n;
  logic [PC_W-1:0]     main_pc, skid_pc;
  logic [DATA_W-1:0]   main_instr, skid_instr;
  logic                accept, consume;
  logic                ld_main_in, ld_main_skid, ld_skid;
  instr_fields_t       fields;

  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign accept    = in_valid & in_ready;
  assign consume   = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= EMPTY;
    else      state <= state_n;
  end

  // Flush wins over everything: the word accepted in the same cycle is
  // dropped by simply not loading it. Register contents are left alone.
  always_comb begin
    state_n      = state;
    ld_main_in   = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;
    if (flush) begin
      state_n = EMPTY;
    end else begin
      case (state)
        EMPTY: if (accept) begin
          state_n    = ONE;
          ld_main_in = 1'b1;
        end
        ONE: begin
          if (accept && !consume) begin
            state_n = FULL;
            ld_skid = 1'b1;
          end else if (accept && consume) begin
            ld_main_in = 1'b1;
          end else if (consume) begin
            state_n = EMPTY;
          end
        end
        FULL: if (consume) begin
          state_n      = ONE;
          ld_main_skid = 1'b1;
        end
        default: state_n = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_pc    <= '0;
      main_instr <= '0;
      skid_pc    <= '0;
      skid_instr <= '0;
    end else begin
      if (ld_main_in) begin
        main_pc    <= in_pc;
        main_instr <= in_instr;
      end else if (ld_main_skid) begin
        main_pc    <= skid_pc;
        main_instr <= skid_instr;
      end
      if (ld_skid) begin
        skid_pc    <= in_pc;
        skid_instr <= in_instr;
      end
    end
  end

  instr_field_split #(.DATA_W(DATA_W), .IMM_W(IMM_W)) u_split (
    .instr  (main_instr),
    .fields (fields)
  );

  assign out_pc     = main_pc;
  assign out_instr  = main_instr;
  assign out_opcode = fields.opcode;
  assign out_rd     = fields.rd;
  assign out_rs1    = fields.rs1;
  assign out_rs2    = fields.rs2;
  assign out_imm    = fields.imm;

`ifdef FETCH_DECODE_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      stall_cnt <= '0;
    else if (out_valid && !out_ready && (stall_cnt != 16'hFFFF))
      stall_cnt <= stall_cnt + 16'd1;
  end
`endif

endmodule

// File: doc/fetch_decode_reg.md
Name: fetch_decode_reg

Overview:
- Pipeline boundary directly downstream of the fetch stage.
- Captures each 32-bit big-endian instruction word and its 8-bit fetch address into a 2-entry skid buffer with valid/ready handshake.
- Presents registered instruction fields (opcode, register indices, sign-extended immediate) to the decode/execute logic.
- Supports downstream back-pressure (stall) and a synchronous pipeline flush for branches.

Parameters:
- DATA_W, 32, instruction word width.
- PC_W, 8, fetch address width.
- IMM_W, 16, immediate field width before sign extension to DATA_W.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous discard of all buffered instructions.
- in_valid  in  1  fetch presents a valid word.
- in_pc  in  PC_W  address of the presented word.
- in_instr  in  DATA_W  instruction word; byte 0 at [31:24].
- in_ready  out  1  block can accept a word this cycle.
- out_valid  out  1  output slot holds a valid instruction.
- out_ready  in  1  downstream consumes the output this cycle.
- out_pc  out  PC_W  address of the output instruction.
- out_instr  out  DATA_W  raw output instruction.
- out_opcode  out  6  out_instr[31:26].
- out_rd  out  5  out_instr[25:21].
- out_rs1  out  5  out_instr[20:16].
- out_rs2  out  5  out_instr[15:11].
- out_imm  out  DATA_W  out_instr[15:0], sign-extended.

Behaviour:
- Reset (rst=0, asynchronous): state EMPTY; out_valid=0; in_ready=1; out_pc=0; out_instr=0, so all decoded fields read 0; skid register=0.
- Transfer rules:
  - accept = in_valid & in_ready.
  - consume = out_valid & out_ready.
  - Data is sampled only on accept.
- Output fields are combinational slices of the main register.
- Registers: main (drives the outputs) and skid.
- States and outputs:
  - EMPTY: out_valid=0.
  - ONE: out_valid=1.
  - FULL: out_valid=1.
  - in_ready = (state != FULL), decoded from the state register only, with no combinational path from out_ready.
- EMPTY:
  - accept -> ONE, main <= input.
  - otherwise stay.
- ONE:
  - accept & !consume -> FULL, skid <= input.
  - !accept & consume -> EMPTY.
  - accept & consume -> ONE, main <= input.
  - neither -> hold.
- FULL:
  - consume -> ONE, main <= skid.
  - otherwise hold; in_ready=0 so no accept is possible.
- Latency: word accepted in cycle N appears at the outputs in cycle N+1 when EMPTY, or when ONE with a simultaneous consume.
- Ordering: strict FIFO; no word is dropped or duplicated without a flush.
- flush=1 has highest priority:
  - next state is EMPTY and out_valid=0 in the next cycle.
  - any accept in the same cycle is discarded.
  - register contents are don't-care but are not cleared.
- A consume coincident with flush still counts as consumed by downstream.
- Stall: out_ready=0 holds out_pc, out_instr and all fields stable for as long as out_valid=1.
- Reset asserted mid-operation aborts immediately to the reset values; the first accept after release behaves as from EMPTY.

Optional Feature:
- Macro: FETCH_DECODE_STALL_CNT_EN.
- When defined:
  - Adds output port stall_cnt, 16 bits, counting cycles with out_valid=1 and out_ready=0.
  - The counter saturates at 16'hFFFF.
  - It resets to 0 on rst only; flush does not clear it.
- When undefined: the port and counter are absent and behaviour is otherwise identical.

Decomposition:
- Package fetch_decode_pkg holds:
  - state enum {EMPTY, ONE, FULL}.
  - field msb/lsb constants.
  - OPCODE_W=6 and REG_W=5.
  - packed struct instr_fields_t {opcode, rd, rs1, rs2, imm}.
- One combinational sub-module, instr_field_split, maps a DATA_W word to instr_fields_t including sign extension. It is reused later by the decoder.

Test Plan:
- Reset check: rst=0 then released -> out_valid=0, in_ready=1, out_instr=0, out_imm=0.
- Single word:
  - Stimulus: in_valid=1, in_pc=8'h04, in_instr=32'h8C22_FFFC, out_ready=1.
  - Response next cycle: out_valid=1, out_pc=8'h04, out_opcode=6'h23, out_rd=1, out_rs1=2, out_rs2=5'h1F, out_imm=32'hFFFF_FFFC.
- Back-pressure:
  - Stimulus: out_ready=0 while sending words A=32'h1111_0001, B=32'h2222_0002, C=32'h3333_0003 back to back.
  - Response: A is held at the outputs; in_ready=0 after B is accepted; C stays pending.
  - Then raise out_ready: outputs are A, B, C in order with no loss.
- Streaming: in_valid=1 and out_ready=1 for 10 cycles with pc 0..9 -> out_pc follows one cycle later each cycle; state never FULL.
- Flush in FULL: flush=1 together with in_valid=1 and a new word -> next cycle out_valid=0 and in_ready=1; that new word never appears at the outputs.
- Stall counter (macro defined): out_valid=1 with out_ready=0 for 5 cycles -> stall_cnt=5; value persists across a flush.
